rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: RR_ENABLE, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wb0_valid  input  1  requester 0 (ALU writeback) write request.
REQ-006 wb0_addr  input  5  requester 0 destination register.
REQ-007 wb0_data  input  32  requester 0 write data.
REQ-008 wb0_ready  output  1  requester 0 accepted this cycle.
REQ-009 wb1_valid, wb1_addr, wb1_data, wb1_ready  same widths/directions  requester 1 (load/multi-cycle unit).
REQ-010 rsv_valid  input  1  issue stage reserves a destination register.
REQ-011 rsv_addr  input  5  register being reserved.
REQ-012 rs1_addr, rs2_addr  input  5 each  hazard query addresses.
REQ-013 rs1_busy, rs2_busy  output  1 each  the queried register has a pending write.
REQ-014 wr_enable  output  1  register-file write enable.
REQ-015 wr_addr  output  5  register-file write address.
REQ-016 wr_data  output  32  register-file write data.
REQ-017 busy_vec  output  32  scoreboard, bit i = register i pending.

Function
REQ-018 Transfer on requester n: wbn_valid && wbn_ready at a rising edge; at most one transfer per cycle.
REQ-019 wbn_ready combinational from valids and arbiter state; wbn_ready is never 1 while wbn_valid is 0.
REQ-020 Only one valid: that requester is granted in the same cycle.
REQ-021 Both valid, RR_ENABLE=1: grant the requester not granted at the last transfer; last_grant resets to 1, so requester 0 wins the first contention.
REQ-022 Both valid, RR_ENABLE=0: requester 0 is always granted.
REQ-023 last_grant updates only on a transfer; idle cycles leave it unchanged.
REQ-024 Write port is registered: a transfer at edge k drives wr_enable=1 with the transferred addr/data during cycle k+1; no transfer drives wr_enable=0.
REQ-025 A transfer with addr 0 is accepted (ready=1) and discarded: wr_enable stays 0 next cycle, busy_vec unaffected.
REQ-026 wr_addr/wr_data hold their previous values when wr_enable=0.
REQ-027 rsv_valid with rsv_addr!=0 sets busy_vec[rsv_addr] at the next edge; rsv_addr=0 is ignored; busy_vec[0] is always 0.
REQ-028 Edge with wr_enable=1 clears busy_vec[wr_addr] (same edge the register file captures the data).
REQ-029 Same-edge reserve and clear of the same address: reserve wins, bit stays 1.
REQ-030 Reserving an already-busy register is legal; bit stays 1, with no error indication.
REQ-031 rsN_busy = busy_vec[rsN_addr], combinational, with no bypass of a same-cycle clear, so a write in flight reads busy until the edge that commits it.
REQ-032 Requester data/addr are sampled only at the transfer edge; a requester may change them freely while not ready.

Reset
REQ-033 While reset=1 at an edge: wr_enable=0, wr_addr=0, wr_data=0, busy_vec=0, last_grant=1; wb0_ready and wb1_ready are forced to 0 during reset.
REQ-034 Reset overrides a same-edge transfer or reservation; a write accepted before reset and pending in the output register is dropped (wr_enable=0 after reset).

Verification
REQ-035 Single: wb0 valid, addr 5, data 0xDEADBEEF, wb1 idle -> wb0_ready=1 same cycle; next cycle wr_enable=1, wr_addr=5, wr_data=0xDEADBEEF.
REQ-036 Contention, RR=1: both valid for 4 cycles (addr 3 / addr 7) -> grants 0,1,0,1; wr_addr sequence 3,7,3,7 one cycle delayed; with RR=0 -> 3,3,3,3 and wb1_ready=0 throughout.
REQ-037 Scoreboard: reserve x10; wb1 write addr 10 accepted at edge k -> rs1_addr=10 gives rs1_busy=1 through cycle k+1, 0 from cycle k+2.
REQ-038 x0: reserve addr 0 and wb0 write addr 0 -> busy_vec stays 0, wb0_ready=1, wr_enable stays 0.
REQ-039 Collision: wr_enable=1 wr_addr=12 and rsv_valid rsv_addr=12 same cycle -> busy_vec[12]=1 afterwards.
REQ-040 Reset mid-operation: transfer at edge k, reset=1 at edge k+1 -> wr_enable=0, busy_vec=0, both readies 0 while reset is held.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: two writeback requesters share one registered
// write port, with a destination-register scoreboard for hazard queries.
module rf_write_arbiter #(
  parameter int RR_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb0_valid,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        wb1_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        wr_enable,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] busy_vec
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              last_grant;
  logic              xfer_p0;
  logic              commit_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [31:0]       busy_q;
  logic [31:0]       busy_nxt;

  // Stage p0: arbitration. last_grant=1 means requester 1 won the last transfer.
  always_comb begin
    wb0_ready = 1'b0;
    wb1_ready = 1'b0;
    if (!reset) begin
      if (wb0_valid && wb1_valid) begin
        if ((RR_ENABLE != 0) && (last_grant == 1'b0)) wb1_ready = 1'b1;
        else                                          wb0_ready = 1'b1;
      end else begin
        wb0_ready = wb0_valid;
        wb1_ready = wb1_valid;
      end
    end
  end

  assign xfer_p0   = wb0_ready | wb1_ready;
  assign addr_p0   = wb1_ready ? wb1_addr : wb0_addr;
  assign data_p0   = wb1_ready ? wb1_data : wb0_data;
  // Writes to x0 are accepted but never reach the register file.
  assign commit_p0 = xfer_p0 && (addr_p0 != '0);

  // Reservation wins over a same-edge clear of the same register.
  always_comb begin
    busy_nxt = busy_q;
    if (vld_p1) busy_nxt[addr_p1] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stage p1: registered write port and scoreboard.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
      last_grant <= 1'b1;
      busy_q     <= '0;
    end else begin
      vld_p1 <= commit_p0;
      if (commit_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
      if (xfer_p0) last_grant <= wb1_ready;
      busy_q <= busy_nxt;
    end
  end

  assign wr_enable = vld_p1;
  assign wr_addr   = addr_p1;
  assign wr_data   = data_p1;
  assign busy_vec  = busy_q;
  // No bypass: a write in flight still reads busy until it commits.
  assign rs1_busy  = busy_q[rs1_addr];
  assign rs2_busy  = busy_q[rs2_addr];

endmodule
